// File: rtl/unified_cache_mem_responder.sv
// rtl/unified_cache_mem_responder.sv - memory-side responder for the unified cache
// Word-addressed backing store; writes complete in IDLE, reads answer after MEM_LATENCY cycles.
module unified_cache_mem_responder #(
  parameter int BLOCK_SIZE_IN_BYTES = 4,
  parameter int ADDR_WIDTH          = 32,
  parameter int PORT_ID_WIDTH       = 2,
  parameter int MEM_DEPTH           = 256,
  parameter int MEM_LATENCY         = 1,
  parameter int DATA_WIDTH          = 8 * BLOCK_SIZE_IN_BYTES,
  parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = 2 + PORT_ID_WIDTH + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] to_mem_packet_in,
  output logic                                          to_mem_packet_ack_out,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] from_mem_packet_out,
  input  logic                                          from_mem_packet_ack_in
);

  localparam int PW        = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int ADDR_LSB  = $clog2(BLOCK_SIZE_IN_BYTES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int CNT_W     = $clog2(MEM_LATENCY + 1);
  localparam int ADDR_POS  = DATA_WIDTH;
  localparam int PORT_POS  = ADDR_POS + ADDR_WIDTH;
  localparam int WR_POS    = PORT_POS + PORT_ID_WIDTH;
  localparam int VALID_POS = WR_POS + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic [PORT_ID_WIDTH-1:0] lat_port, lat_port_next;
  logic [ADDR_WIDTH-1:0]    lat_addr, lat_addr_next;
  logic [PW-1:0]            resp_next;
  logic                     ack_next;
  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

  logic                     req_valid, req_write, accept;
  logic [PORT_ID_WIDTH-1:0] req_port;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]    req_data;
  logic [IDX_W-1:0]         req_idx, lat_idx;

  assign req_valid = to_mem_packet_in[VALID_POS];
  assign req_write = to_mem_packet_in[WR_POS];
  assign req_port  = to_mem_packet_in[PORT_POS +: PORT_ID_WIDTH];
  assign req_addr  = to_mem_packet_in[ADDR_POS +: ADDR_WIDTH];
  assign req_data  = to_mem_packet_in[DATA_WIDTH-1:0];
  assign req_idx   = req_addr[ADDR_LSB +: IDX_W];
  assign lat_idx   = lat_addr[ADDR_LSB +: IDX_W];
  // The registered ack is only high in IDLE, so it alone qualifies acceptance.
  assign accept    = req_valid && to_mem_packet_ack_out;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state                 <= S_IDLE;
      cnt                   <= '0;
      lat_port              <= '0;
      lat_addr              <= '0;
      from_mem_packet_out   <= '0;
      to_mem_packet_ack_out <= 1'b0;
    end else begin
      state                 <= state_next;
      cnt                   <= cnt_next;
      lat_port              <= lat_port_next;
      lat_addr              <= lat_addr_next;
      from_mem_packet_out   <= resp_next;
      to_mem_packet_ack_out <= ack_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept && req_write) begin
      mem[req_idx] <= req_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && !req_write) state_next = S_WAIT;
      S_WAIT: if (cnt == CNT_W'(1)) state_next = S_RESP;
      S_RESP: if (from_mem_packet_ack_in) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_next      = cnt;
    lat_port_next = lat_port;
    lat_addr_next = lat_addr;
    resp_next     = from_mem_packet_out;
    ack_next      = (state_next == S_IDLE);
    case (state)
      S_IDLE: begin
        resp_next = '0;
        if (accept && !req_write) begin
          cnt_next      = CNT_W'(MEM_LATENCY);
          lat_port_next = req_port;
          lat_addr_next = req_addr;
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          resp_next = {1'b1, 1'b0, lat_port, lat_addr, mem[lat_idx]};
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_RESP: if (from_mem_packet_ack_in) resp_next = '0;
      default: resp_next = '0;
    endcase
  end

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
// tb/tb_unified_cache_mem_responder.sv - scoreboard bench for the cache memory responder
// Instance 0 runs MEM_LATENCY=1, instance 1 runs MEM_LATENCY=4.
module tb_unified_cache_mem_responder;

  localparam int PW = 68;

  typedef struct {
    int            u;
    logic [PW-1:0] pkt;
    int            at;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_in;
  logic [PW-1:0] req [2];
  logic [PW-1:0] resp [2];
  logic          ack_out [2];
  logic          resp_ack [2];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];
  bit   prev_v [2];
  int   first_at [2];
  int   a, a0, a1, a2, m;

  unified_cache_mem_responder #(.MEM_LATENCY(1)) dut_l1 (
    .clk_in(clk), .reset_in(reset_in),
    .to_mem_packet_in(req[0]), .to_mem_packet_ack_out(ack_out[0]),
    .from_mem_packet_out(resp[0]), .from_mem_packet_ack_in(resp_ack[0]));

  unified_cache_mem_responder #(.MEM_LATENCY(4)) dut_l4 (
    .clk_in(clk), .reset_in(reset_in),
    .to_mem_packet_in(req[1]), .to_mem_packet_ack_out(ack_out[1]),
    .from_mem_packet_out(resp[1]), .from_mem_packet_ack_in(resp_ack[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic logic [PW-1:0] mk(bit w, logic [1:0] p, logic [31:0] ad, logic [31:0] d);
    return {1'b1, w, p, ad, d};
  endfunction

  task automatic check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Called at a falling edge; returns the rising-edge number at which the packet is taken.
  task automatic send(int u, logic [PW-1:0] pkt, bit exp_r, logic [31:0] d, output int acc);
    exp_t e;
    acc = -1;
    req[u] = pkt;
    for (int i = 0; i < 60 && acc < 0; i++) begin
      if (ack_out[u]) acc = cyc + 1;
      else @(negedge clk);
    end
    if (acc < 0) begin
      fail("send_timeout");
    end else begin
      if (!pkt[66] && exp_r) begin
        e.u   = u;
        e.pkt = {1'b1, 1'b0, pkt[65:32], d};
        e.at  = acc + lat(u);
        sbq.push_back(e);
      end
      @(negedge clk);
    end
    req[u] = '0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        int idx;
        idx = -1;
        if (resp[u][67] === 1'b1) begin
          if (!prev_v[u]) first_at[u] = cyc;
          if (resp_ack[u]) begin
            for (int i = 0; i < sbq.size(); i++) begin
              if (idx < 0 && sbq[i].u == u) idx = i;
            end
            if (idx < 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_resp: got %h expected none", resp[u]);
            end else begin
              check("resp_pkt", resp[u], sbq[idx].pkt);
              check("resp_latency", first_at[u], sbq[idx].at);
              sbq.delete(idx);
            end
          end
        end
        prev_v[u] = (resp[u][67] === 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1;
    req[0] = '0; req[1] = '0;
    resp_ack[0] = 1'b1; resp_ack[1] = 1'b1;
    #1 reset_in = 1'b0;
    req[0] = mk(1'b1, 2'd0, 32'h10, 32'h1);
    req[1] = mk(1'b1, 2'd1, 32'h4, 32'h2);
    repeat (3) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        check("rst_ack", ack_out[u], 0);
        check("rst_resp", resp[u], 0);
      end
    end
    req[0] = '0; req[1] = '0;
    reset_in = 1'b1;
    @(negedge clk);
    check("rel_ack0", ack_out[0], 1);
    check("rel_ack1", ack_out[1], 1);

    send(0, mk(1'b1, 2'd0, 32'h10, 32'hDEADBEEF), 1'b0, 32'h0, a);
    send(0, mk(1'b0, 2'd2, 32'h10, 32'h0), 1'b1, 32'hDEADBEEF, a);
    repeat (3) @(negedge clk);

    send(1, mk(1'b1, 2'd0, 32'h4, 32'h12345678), 1'b0, 32'h0, a);
    send(1, mk(1'b0, 2'd1, 32'h404, 32'h0), 1'b1, 32'h12345678, a);
    for (int i = 0; i < 5; i++) begin
      check("ack_busy", ack_out[1], 0);
      @(negedge clk);
    end
    check("ack_back", ack_out[1], 1);

    send(1, mk(1'b1, 2'd0, 32'h20, 32'hA5A50001), 1'b0, 32'h0, a);
    resp_ack[1] = 1'b0;
    send(1, mk(1'b0, 2'd3, 32'h20, 32'h0), 1'b1, 32'hA5A50001, a1);
    fork
      begin
        for (int i = 0; i < 10 && !resp[1][67]; i++) @(negedge clk);
        if (!resp[1][67]) fail("bp_valid");
        repeat (10) begin
          @(negedge clk);
          check("bp_hold", resp[1], {1'b1, 1'b0, 2'd3, 32'h20, 32'hA5A50001});
          check("bp_ack", ack_out[1], 0);
        end
        resp_ack[1] = 1'b1;
        m = cyc + 1;
      end
      send(1, mk(1'b0, 2'd0, 32'h4, 32'h0), 1'b1, 32'h12345678, a2);
    join
    check("second_accept", a2, m + 1);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(0, mk(1'b1, 2'd0, 32'h40 + 4 * i, 32'hC0DE0000 + i * 32'h111), 1'b0, 32'h0, a);
      if (i == 0) a0 = a;
      else check("b2b_edge", a, a0 + i);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      send(0, mk(1'b0, 2'(i), 32'h40 + 4 * i, 32'h0), 1'b1, 32'hC0DE0000 + i * 32'h111, a);
    end
    repeat (3) @(negedge clk);

    send(1, mk(1'b0, 2'd1, 32'h20, 32'h0), 1'b0, 32'h0, a);
    @(negedge clk);
    reset_in = 1'b0;
    #1;
    check("mid_rst_resp", resp[1], 0);
    check("mid_rst_ack", ack_out[1], 0);
    check("mid_rst_ack0", ack_out[0], 0);
    @(negedge clk);
    @(negedge clk);
    reset_in = 1'b1;
    repeat (8) @(negedge clk);
    send(1, mk(1'b0, 2'd2, 32'h404, 32'h0), 1'b1, 32'h12345678, a);
    send(0, mk(1'b0, 2'd1, 32'h10, 32'h0), 1'b1, 32'hDEADBEEF, a);
    repeat (10) @(negedge clk);
    check("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
